// File: rtl/sobel_stream_acc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sobel_stream_acc: streaming Sobel edge-magnitude core, PX pixels/beat  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sobel_stream_acc #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int PX     = 4,
  parameter int PIX_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    thr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PX*PIX_W-1:0] in_a,
  input  logic [PX*PIX_W-1:0] in_b,
  input  logic [PX*PIX_W-1:0] in_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PX*PIX_W-1:0] out_data,
  output logic                busy,
  output logic                finish
);

  localparam int DW   = PX * PIX_W;
  localparam int EW   = (PX + 2) * PIX_W;
  localparam int COLS = WIDTH / PX;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW   = $clog2(HEIGHT);
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0]    COL_ONE  = CW'(1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thr_q;
  logic             last_row;
  logic             drain_sent;

  // Only the rightmost pixel of the previous word is ever a neighbour.
  logic [PIX_W-1:0] prev_a, prev_b, prev_c;
  logic [DW-1:0]    cur_a, cur_b, cur_c;

  logic             accept, take, emit_run, emit_drain, load_out;
  logic             is_first, at_drain;
  logic [DW-1:0]    a_in, c_in, result;
  logic [PIX_W-1:0] la, lb, lc, ra, rb, rc;
  logic [EW-1:0]    ext_a, ext_b, ext_c;

  assign accept     = in_valid && in_ready;
  assign take       = out_valid && out_ready;
  assign a_in       = (row == '0) ? in_b : in_a;
  assign c_in       = (row == ROW_LAST) ? in_b : in_c;
  assign emit_run   = accept && (col != '0);
  assign emit_drain = (state == DRAIN) && !drain_sent && (!out_valid || out_ready);
  assign load_out   = emit_run || emit_drain;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && (col == COL_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_sent && take) state_nxt = last_row ? DONE : RUN;
      end
      DONE: begin
        finish = 1'b1;
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      mode_q     <= '0;
      thr_q      <= '0;
      last_row   <= 1'b0;
      drain_sent <= 1'b0;
      prev_a     <= '0;
      prev_b     <= '0;
      prev_c     <= '0;
      cur_a      <= '0;
      cur_b      <= '0;
      cur_c      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        col    <= '0;
        row    <= '0;
        mode_q <= mode;
        thr_q  <= thr;
      end
      if (accept) begin
        prev_a <= cur_a[PIX_W-1:0];
        prev_b <= cur_b[PIX_W-1:0];
        prev_c <= cur_c[PIX_W-1:0];
        cur_a  <= a_in;
        cur_b  <= in_b;
        cur_c  <= c_in;
        if (col == COL_LAST) begin
          col        <= '0;
          last_row   <= (row == ROW_LAST);
          row        <= (row == ROW_LAST) ? '0 : row + 1'b1;
          drain_sent <= 1'b0;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (emit_drain) drain_sent <= 1'b1;
      // A new result may replace a word taken in the same cycle: no bubble.
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= result;
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Neighbour pixels: replicate at the row ends, otherwise borrow from P / incoming word.
  assign is_first = (state == RUN) && (col == COL_ONE);
  assign at_drain = (state == DRAIN);
  assign la = is_first ? cur_a[DW-1 -: PIX_W] : prev_a;
  assign lb = is_first ? cur_b[DW-1 -: PIX_W] : prev_b;
  assign lc = is_first ? cur_c[DW-1 -: PIX_W] : prev_c;
  assign ra = at_drain ? cur_a[PIX_W-1:0] : a_in[DW-1 -: PIX_W];
  assign rb = at_drain ? cur_b[PIX_W-1:0] : in_b[DW-1 -: PIX_W];
  assign rc = at_drain ? cur_c[PIX_W-1:0] : c_in[DW-1 -: PIX_W];
  assign ext_a = {la, cur_a, ra};
  assign ext_b = {lb, cur_b, rb};
  assign ext_c = {lc, cur_c, rc};

  function automatic logic [PIX_W-1:0] sat(input logic [PIX_W+2:0] v);
    return (v > {3'b000, PIX_MAX}) ? PIX_MAX : v[PIX_W-1:0];
  endfunction

  generate
    for (genvar i = 0; i < PX; i++) begin : g_pix
      localparam int HI = EW - 1 - i * PIX_W;
      logic [PIX_W-1:0] a0, a1, a2, b0, b2, c0, c1, c2, px;
      logic [PIX_W+1:0] sl, sr, ta, tc, gx, gy;
      logic [PIX_W+2:0] mag;

      assign a0 = ext_a[HI -: PIX_W];
      assign a1 = ext_a[HI - PIX_W -: PIX_W];
      assign a2 = ext_a[HI - 2 * PIX_W -: PIX_W];
      assign b0 = ext_b[HI -: PIX_W];
      assign b2 = ext_b[HI - 2 * PIX_W -: PIX_W];
      assign c0 = ext_c[HI -: PIX_W];
      assign c1 = ext_c[HI - PIX_W -: PIX_W];
      assign c2 = ext_c[HI - 2 * PIX_W -: PIX_W];

      assign sl  = {2'b00, a0} + {1'b0, b0, 1'b0} + {2'b00, c0};
      assign sr  = {2'b00, a2} + {1'b0, b2, 1'b0} + {2'b00, c2};
      assign ta  = {2'b00, a0} + {1'b0, a1, 1'b0} + {2'b00, a2};
      assign tc  = {2'b00, c0} + {1'b0, c1, 1'b0} + {2'b00, c2};
      assign gx  = (sr >= sl) ? (sr - sl) : (sl - sr);
      assign gy  = (ta >= tc) ? (ta - tc) : (tc - ta);
      assign mag = {1'b0, gx} + {1'b0, gy};

      always_comb begin
        case (mode_q)
          2'b00:   px = sat(mag);
          2'b01:   px = sat({1'b0, gx});
          2'b10:   px = sat({1'b0, gy});
          default: px = (mag >= {3'b000, thr_q}) ? PIX_MAX : '0;
        endcase
      end

      assign result[DW - 1 - i * PIX_W -: PIX_W] = px;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_acc.sv
`default_nettype none
// Bench for sobel_stream_acc on a 16x4 frame, 4 pixels/word: directed images plus
// a randomly throttled stream checked against a per-pixel Sobel model.
module tb_sobel_stream_acc;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 4;
  localparam int PX     = 4;
  localparam int PIX_W  = 8;
  localparam int COLS   = WIDTH / PX;
  localparam int TOTAL  = COLS * HEIGHT;
  localparam int DW     = PX * PIX_W;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [1:0]    mode;
  logic [7:0]    thr;
  logic [DW-1:0] in_a, in_b, in_c, out_data;
  logic          in_ready, out_valid, busy, finish;

  always #5 clk = ~clk;

  sobel_stream_acc #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PX(PX), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .thr(thr),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .finish(finish)
  );

  logic [7:0]    img [HEIGHT][WIDTH];
  logic [DW-1:0] got [$];
  int            tests = 0;
  int            fails = 0;

  // Out-of-frame rows carry a junk pattern that the core must ignore.
  function automatic logic [DW-1:0] pack_row(int y, int w);
    logic [DW-1:0] v;
    for (int j = 0; j < PX; j++)
      v[DW-1-j*PIX_W -: PIX_W] = (y < 0 || y >= HEIGHT) ? 8'hA5 : img[y][w*PX+j];
    return v;
  endfunction

  function automatic int pix(int y, int x);
    int yy, xx;
    yy = (y < 0) ? 0 : ((y >= HEIGHT) ? HEIGHT - 1 : y);
    xx = (x < 0) ? 0 : ((x >= WIDTH) ? WIDTH - 1 : x);
    return int'(img[yy][xx]);
  endfunction

  function automatic logic [7:0] ref_pix(int y, int x, logic [1:0] m, int t);
    int gx, gy, s;
    gx = (pix(y-1, x+1) + 2*pix(y, x+1) + pix(y+1, x+1))
       - (pix(y-1, x-1) + 2*pix(y, x-1) + pix(y+1, x-1));
    gy = (pix(y-1, x-1) + 2*pix(y-1, x) + pix(y-1, x+1))
       - (pix(y+1, x-1) + 2*pix(y+1, x) + pix(y+1, x+1));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      2'b00:   s = gx + gy;
      2'b01:   s = gx;
      2'b10:   s = gy;
      default: s = (gx + gy >= t) ? 255 : 0;
    endcase
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic run_frame(input logic [1:0] m, input logic [7:0] t, input int vpct, input int rpct);
    int idx, cyc, stall_err;
    logic held_v, done;
    logic [DW-1:0] held_d;
    got.delete();
    idx = 0; stall_err = 0; held_v = 1'b0; held_d = '0; done = 1'b0;
    mode = m; thr = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; thr = ~t;
    for (cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (idx < TOTAL && $urandom_range(99) < vpct) begin
        in_valid = 1'b1;
        in_a = pack_row(idx / COLS - 1, idx % COLS);
        in_b = pack_row(idx / COLS,     idx % COLS);
        in_c = pack_row(idx / COLS + 1, idx % COLS);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (held_v && (!out_valid || out_data !== held_d)) stall_err++;
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      if (finish) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL frame_finish: finish not seen after %0d cycles, expected finish=1", cyc);
    end
    tests++;
    if (got.size() != TOTAL) begin
      fails++;
      $display("FAIL frame_count: got %0d outputs, expected %0d", got.size(), TOTAL);
    end
    tests++;
    if (stall_err != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d stalled cycles changed out_data/out_valid, expected 0", stall_err);
    end
    tests++;
    if (busy !== 1'b0 || finish !== 1'b0) begin
      fails++;
      $display("FAIL back_to_idle: busy=%b finish=%b, expected 0 0", busy, finish);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 2'b00; thr = 8'h00;
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_c = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, in_ready, busy, finish} !== 4'b0000 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_state: valid/ready/busy/finish=%b data=%h, expected 0000 0",
               {out_valid, in_ready, busy, finish}, out_data);
    end
    rst = 1'b0;
    for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = 8'h80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      in_valid = 1'b1;
      in_a = pack_row(-1, w); in_b = pack_row(0, w); in_c = pack_row(1, w);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midframe_active: out_valid=%b busy=%b, expected 1 1", out_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, in_ready, busy, finish} !== 4'b0000) begin
      fails++;
      $display("FAIL midframe_reset: valid/ready/busy/finish=%b, expected 0000",
               {out_valid, in_ready, busy, finish});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_flat();
    for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = 8'h80;
    run_frame(2'b00, 8'h00, 100, 100);
    for (int k = 0; k < got.size(); k++) begin
      tests++;
      if (got[k] !== '0) begin
        fails++;
        $display("FAIL flat_word%0d: got %h, expected %h", k, got[k], 32'h0);
      end
    end
  endtask

  task automatic test_vstep();
    logic [DW-1:0] e;
    for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = (x < 8) ? 8'h00 : 8'hFF;
    run_frame(2'b01, 8'h00, 100, 100);
    for (int k = 0; k < got.size(); k++) begin
      for (int j = 0; j < PX; j++) begin
        int x;
        x = (k % COLS) * PX + j;
        e[DW-1-j*PIX_W -: PIX_W] = (x == 7 || x == 8) ? 8'hFF : 8'h00;
      end
      tests++;
      if (got[k] !== e) begin
        fails++;
        $display("FAIL vstep_gx_word%0d: got %h, expected %h", k, got[k], e);
      end
    end
    run_frame(2'b10, 8'h00, 100, 100);
    for (int k = 0; k < got.size(); k++) begin
      tests++;
      if (got[k] !== '0) begin
        fails++;
        $display("FAIL vstep_gy_word%0d: got %h, expected %h", k, got[k], 32'h0);
      end
    end
  endtask

  task automatic test_hstep();
    logic [DW-1:0] e;
    for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = (y < 2) ? 8'h00 : 8'hFF;
    run_frame(2'b10, 8'h00, 100, 100);
    for (int k = 0; k < got.size(); k++) begin
      e = (k / COLS == 1 || k / COLS == 2) ? {DW{1'b1}} : '0;
      tests++;
      if (got[k] !== e) begin
        fails++;
        $display("FAIL hstep_row%0d_word%0d: got %h, expected %h", k / COLS, k % COLS, got[k], e);
      end
    end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] e;
    for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = 8'(x);
    run_frame(2'b11, 8'd8, 100, 100);
    for (int k = 0; k < got.size(); k++) begin
      for (int j = 0; j < PX; j++) begin
        int x;
        x = (k % COLS) * PX + j;
        e[DW-1-j*PIX_W -: PIX_W] = (x == 0 || x == WIDTH - 1) ? 8'h00 : 8'hFF;
      end
      tests++;
      if (got[k] !== e) begin
        fails++;
        $display("FAIL ramp_thr_word%0d: got %h, expected %h", k, got[k], e);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] e;
    logic [7:0]    t;
    for (int m = 0; m < 4; m++) begin
      for (int y = 0; y < HEIGHT; y++) for (int x = 0; x < WIDTH; x++) img[y][x] = 8'($urandom_range(255));
      t = 8'($urandom_range(255));
      run_frame(2'(m), t, 70, 50);
      for (int k = 0; k < got.size(); k++) begin
        for (int j = 0; j < PX; j++)
          e[DW-1-j*PIX_W -: PIX_W] = ref_pix(k / COLS, (k % COLS) * PX + j, 2'(m), int'(t));
        tests++;
        if (got[k] !== e) begin
          fails++;
          $display("FAIL random_m%0d_word%0d: got %h, expected %h", m, k, got[k], e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_vstep();
    test_hstep();
    test_ramp();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
